mem_rr_arbiter: RTL

- Shares one simple dual-port synchronous memory between NUM_REQ requesters.
- The memory has one write port and one read port, with registered read data at 1-cycle latency.
- Two independent round-robin arbiters are used: one for reads, one for writes. Each cycle, at most one read and one write are granted.
- The block sits between the client logic and the memory instance. It drives the memory's rd_en/rd_addr/wr_en/wr_addr/wr_data and routes the returned rd_data back to the owning requester.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mem_rr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared defaults and helpers for the memory round-robin arbiter.
//   DEF_DATA_WIDTH / DEF_MAX_ADDR / DEF_NUM_REQ : default configuration
//   next_ptr(idx, n)                            : (idx + 1) mod n
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_MAX_ADDR   = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first set bit of req_i
// searching upward from ptr_i, wrapping modulo N.
// Ports:
//   req_i     [N-1:0] request vector
//   ptr_i     [W-1:0] search start index (must be < N)
//   gnt_o     [N-1:0] one-hot grant (zero when no request)
//   gnt_any_o         any grant issued
//   gnt_idx_o [W-1:0] index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         gnt_any_o,
  output logic [W-1:0] gnt_idx_o
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = W'((32'(ptr_i) + off) % N);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_any_o  = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Shares one simple dual-port synchronous memory (1 write port, 1 read port,
// 1-cycle registered read) between NUM_REQ requesters using independent
// round-robin arbiters for reads and writes.
// Optional feature macro: MEM_ARB_BYPASS_EN
//   defined   : same-cycle read/write to the same address returns the new
//               write data (read-after-write) via a registered bypass.
//   undefined : read-before-write; rsp_data always follows mem_rd_data.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/req_we  per-requester pending access and direction (1 = write)
//   req_addr/req_wdata packed per-requester address and write data
//   req_ready         grant; transfer completes on req_valid & req_ready
//   rsp_valid         one-hot owner of rsp_data this cycle
//   rsp_data          read return data (0 when rsp_valid is 0)
//   mem_*             memory port drive and returned read data
// -----------------------------------------------------------------------------
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_ADDR   = DEF_MAX_ADDR,
  parameter int unsigned ADDRSIZE   = $clog2(MAX_ADDR),
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDRSIZE-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           mem_rd_en,
  output logic [ADDRSIZE-1:0]            mem_rd_addr,
  output logic                           mem_wr_en,
  output logic [ADDRSIZE-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0]          mem_wr_data,
  input  logic [DATA_WIDTH-1:0]          mem_rd_data
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rd_req, wr_req;
  logic [NUM_REQ-1:0] rd_gnt_raw, wr_gnt_raw;
  logic [NUM_REQ-1:0] rd_gnt, wr_gnt;
  logic               rd_any_raw, wr_any_raw;
  logic               rd_any, wr_any;
  logic [PW-1:0]      rd_idx, wr_idx;

  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q;

  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid &  req_we;

  rr_arbiter #(.N(NUM_REQ), .W(PW)) u_rd_arb (
    .req_i     (rd_req),
    .ptr_i     (rd_ptr_q),
    .gnt_o     (rd_gnt_raw),
    .gnt_any_o (rd_any_raw),
    .gnt_idx_o (rd_idx)
  );

  rr_arbiter #(.N(NUM_REQ), .W(PW)) u_wr_arb (
    .req_i     (wr_req),
    .ptr_i     (wr_ptr_q),
    .gnt_o     (wr_gnt_raw),
    .gnt_any_o (wr_any_raw),
    .gnt_idx_o (wr_idx)
  );

  // Reset suppresses every grant, so nothing downstream sees a handshake.
  assign rd_gnt    = rst ? '0 : rd_gnt_raw;
  assign wr_gnt    = rst ? '0 : wr_gnt_raw;
  assign rd_any    = rd_any_raw & ~rst;
  assign wr_any    = wr_any_raw & ~rst;
  assign req_ready = rd_gnt | wr_gnt;

  // One-hot OR-mux of the winners' address/data onto the memory ports.
  always_comb begin
    mem_rd_en   = rd_any;
    mem_wr_en   = wr_any;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) mem_rd_addr = mem_rd_addr | req_addr[i*ADDRSIZE +: ADDRSIZE];
      if (wr_gnt[i]) begin
        mem_wr_addr = mem_wr_addr | req_addr[i*ADDRSIZE +: ADDRSIZE];
        mem_wr_data = mem_wr_data | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_any) rd_ptr_d = PW'(next_ptr(32'(rd_idx), NUM_REQ));
    if (wr_any) wr_ptr_d = PW'(next_ptr(32'(wr_idx), NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rd_gnt;
    end
  end

  // Output gated by rst so a read granted just before reset never responds.
  assign rsp_valid = rst ? '0 : rsp_valid_q;

`ifdef MEM_ARB_BYPASS_EN
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_d      = rd_any && wr_any && (mem_rd_addr == mem_wr_addr);
    byp_data_d = byp_d ? mem_wr_data : byp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rsp_data = (|rsp_valid) ? (byp_q ? byp_data_q : mem_rd_data) : '0;
`else
  assign rsp_data = (|rsp_valid) ? mem_rd_data : '0;
`endif

endmodule
